// File: rtl/encoder_pkg.sv
// Shared types and helpers for the bit-scan encoder family.
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index width that never collapses to zero bits, even for tiny vectors.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational find-first-set: binary index and one-hot of the winning bit.
// Replaces the fixed 8-to-3 encoder for new designs.
module priority_encoder
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1,
  localparam int W        = clog2_min1(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any
);

  // NOTE: every output gets a default before the loop, otherwise a path that
  // finds no set bit would leave it unassigned and infer a latch.
  always_comb begin
    idx    = '0;
    onehot = '0;
    any    = |vec;
    // Last match in the loop wins, so scan away from the preferred end.
    if (LSB_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx       = W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) begin
          idx       = W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bitscan_encoder.sv
// Accepts an N-bit request vector and streams out the index of each set bit,
// one per output beat; an all-zero vector yields a single flagged beat.
module bitscan_encoder
  import encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1,
  localparam int W        = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
);

  state_t       state, state_next;
  logic [N-1:0] pending, pending_next;
  logic [N-1:0] sel_onehot;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         accept;
  logic         fire;

  priority_encoder #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_pe (
    .vec    (pending),
    .idx    (sel_idx),
    .onehot (sel_onehot),
    .any    (sel_any)
  );

  // Outputs depend only on the held vector; in_vec never reaches them.
  assign out_valid = (state == SCAN);
  assign out_idx   = sel_idx;
  assign out_last  = (state == SCAN) && ((pending & ~sel_onehot) == '0);
  assign out_none  = (state == SCAN) && !sel_any;

  assign fire     = out_valid && out_ready;
  assign in_ready = (state == IDLE) || (fire && out_last);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    if (accept) begin
      // A new vector on the final beat replaces the old one with no bubble.
      pending_next = in_vec;
      state_next   = SCAN;
    end else if (fire) begin
      pending_next = pending & ~sel_onehot;
      if (out_last) state_next = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Directed and randomised checks of bitscan_encoder at N=8 (both orders) and N=32.
module tb_bitscan_encoder;

  logic clk;
  logic rst_n;

  // Two 8-bit instances share stimulus; only the emission order differs.
  logic       in_valid8, out_ready8;
  logic [7:0] in_vec8;
  logic       in_ready_a, out_valid_a, out_last_a, out_none_a;
  logic [2:0] out_idx_a;
  logic       in_ready_b, out_valid_b, out_last_b, out_none_b;
  logic [2:0] out_idx_b;

  logic        in_valid32, out_ready32;
  logic [31:0] in_vec32;
  logic        in_ready32, out_valid32, out_last32, out_none32;
  logic [4:0]  out_idx32;

  int total = 0;
  int bad   = 0;

  bitscan_encoder #(.N(8), .LSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready_a), .in_vec(in_vec8),
    .out_valid(out_valid_a), .out_ready(out_ready8), .out_idx(out_idx_a),
    .out_last(out_last_a), .out_none(out_none_a)
  );

  bitscan_encoder #(.N(8), .LSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready_b), .in_vec(in_vec8),
    .out_valid(out_valid_b), .out_ready(out_ready8), .out_idx(out_idx_b),
    .out_last(out_last_b), .out_none(out_none_b)
  );

  bitscan_encoder #(.N(32), .LSB_FIRST(1)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_vec(in_vec32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_idx(out_idx32),
    .out_last(out_last32), .out_none(out_none32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  vec;
    logic [31:0] seq_lo;  // nibble k = index of beat k, lowest-first instance
    logic [31:0] seq_hi;  // nibble k = index of beat k, highest-first instance
    int          cnt;
    logic        none;
  } vec_t;

  vec_t tbl[7];

  // Offers one vector with out_ready held high and checks every beat of both 8-bit instances.
  task automatic run8(input logic [7:0] vec, input logic [31:0] sl, input logic [31:0] sh,
                      input int cnt, input logic none);
    @(negedge clk);
    in_vec8    = vec;
    in_valid8  = 1'b1;
    out_ready8 = 1'b1;
    #1;
    check("accept_ready", in_ready_a, 1'b1);
    @(negedge clk);
    in_valid8 = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      check("beat_valid", out_valid_a, 1'b1);
      check("beat_idx_lo", out_idx_a, sl[4*k +: 3]);
      check("beat_idx_hi", out_idx_b, sh[4*k +: 3]);
      check("beat_last_lo", out_last_a, (k == cnt - 1));
      check("beat_last_hi", out_last_b, (k == cnt - 1));
      check("beat_none", out_none_a, none);
      @(negedge clk);
    end
    check("done_idle", out_valid_a, 1'b0);
  endtask

  function automatic logic [31:0] gen_vec();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h1 << $urandom_range(0, 31);
      2:       return $urandom & $urandom;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   q_idx[$];
    logic q_last[$];
    logic q_none[$];
    logic have;
    int   sent;
    int   exp_beats;
    int   got_beats;

    rst_n       = 1'b0;
    in_valid8   = 1'b0;
    out_ready8  = 1'b0;
    in_vec8     = '0;
    in_valid32  = 1'b0;
    out_ready32 = 1'b0;
    in_vec32    = '0;

    tbl[0] = '{8'hA6, 32'h0000_7521, 32'h0000_1257, 4, 1'b0};
    tbl[1] = '{8'h00, 32'h0,         32'h0,         1, 1'b1};
    tbl[2] = '{8'h01, 32'h0,         32'h0,         1, 1'b0};
    tbl[3] = '{8'h80, 32'h7,         32'h7,         1, 1'b0};
    tbl[4] = '{8'hFF, 32'h7654_3210, 32'h0123_4567, 8, 1'b0};
    tbl[5] = '{8'h18, 32'h0000_0043, 32'h0000_0034, 2, 1'b0};
    tbl[6] = '{8'hC3, 32'h0000_7610, 32'h0000_0167, 4, 1'b0};

    #3;
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_out_idx", out_idx_a, 3'd0);
    check("rst_out_last", out_last_a, 1'b0);
    check("rst_out_none", out_none_a, 1'b0);
    check("rst_w_valid", out_valid32, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++)
      run8(tbl[t].vec, tbl[t].seq_lo, tbl[t].seq_hi, tbl[t].cnt, tbl[t].none);

    // Backpressure: first beat must hold while the consumer stalls.
    @(negedge clk);
    in_vec8 = 8'h81; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", out_valid_a, 1'b1);
      check("bp_idx", out_idx_a, 3'd0);
      check("bp_idx_hi", out_idx_b, 3'd7);
      check("bp_last", out_last_a, 1'b0);
      check("bp_in_ready", in_ready_a, 1'b0);
      @(negedge clk);
    end
    out_ready8 = 1'b1;
    #1;
    check("bp_rel_idx0", out_idx_a, 3'd0);
    check("bp_rel_ready0", in_ready_a, 1'b0);
    @(negedge clk);
    check("bp_rel_idx7", out_idx_a, 3'd7);
    check("bp_rel_last", out_last_a, 1'b1);
    @(negedge clk);
    check("bp_idle", out_valid_a, 1'b0);

    // Back-to-back: second vector accepted on the final beat of the first.
    @(negedge clk);
    in_vec8 = 8'h03; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk);
    #1 in_vec8 = 8'h80;
    @(negedge clk);
    check("b2b_idx0", out_idx_a, 3'd0);
    check("b2b_ready0", in_ready_a, 1'b0);
    @(negedge clk);
    check("b2b_idx1", out_idx_a, 3'd1);
    check("b2b_last1", out_last_a, 1'b1);
    check("b2b_ready1", in_ready_a, 1'b1);
    @(negedge clk);
    check("b2b_valid7", out_valid_a, 1'b1);
    check("b2b_idx7", out_idx_a, 3'd7);
    check("b2b_last7", out_last_a, 1'b1);
    in_valid8 = 1'b0;
    @(negedge clk);
    check("b2b_idle", out_valid_a, 1'b0);

    // Reset mid-scan.
    @(negedge clk);
    in_vec8 = 8'hFF; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    check("mid_first_idx", out_idx_a, 3'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_a, 1'b0);
    check("mid_rst_ready", in_ready_a, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h10, 32'h4, 32'h4, 1, 1'b0);

    // Random sweep at N=32 with a queue scoreboard.
    have = 1'b0; sent = 0; exp_beats = 0; got_beats = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (!have && sent < 150) begin
        in_vec32   = gen_vec();
        in_valid32 = 1'b1;
        have       = 1'b1;
        sent++;
      end else if (!have) begin
        in_valid32 = 1'b0;
      end
      out_ready32 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid32 && out_ready32) begin
        if (q_idx.size() == 0) begin
          check("rand_unexpected_beat", 1'b1, 1'b0);
        end else begin
          check("rand_beat", {out_none32, out_last32, out_idx32},
                {q_none[0], q_last[0], 5'(q_idx[0])});
          void'(q_idx.pop_front());
          void'(q_last.pop_front());
          void'(q_none.pop_front());
          got_beats++;
        end
      end
      if (in_valid32 && in_ready32) begin
        if (in_vec32 == '0) begin
          q_idx.push_back(0); q_last.push_back(1'b1); q_none.push_back(1'b1);
          exp_beats++;
        end else begin
          for (int i = 0; i < 32; i++) begin
            if (in_vec32[i]) begin
              q_idx.push_back(i); q_last.push_back(1'b0); q_none.push_back(1'b0);
            end
          end
          q_last[q_last.size() - 1] = 1'b1;
          exp_beats += $countones(in_vec32);
        end
        have = 1'b0;
      end
      if (sent == 150 && !have && q_idx.size() == 0 && !out_valid32) break;
    end
    check("rand_sent", sent, 150);
    check("rand_drained", q_idx.size(), 0);
    check("rand_beat_count", got_beats, exp_beats);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitscan_encoder.md
# bitscan_encoder

- Parametrised, sequential successor to the fixed 8-to-3 one-hot encoder.
- Accepts an N-bit request vector over a valid/ready handshake and emits the binary index of every set bit, one index per accepted output beat, in a selectable priority order.
- Zero vectors produce a flagged beat instead of an undefined output.
- Sits between request collectors (interrupt lines, arbiter grants, cache-way hits) and consumers that process one index at a time.

## Interface
- `N`, default 8: input vector width; N ≥ 2.
- `LSB_FIRST`, default 1: 1 emits the lowest set index first; 0 emits the highest first.
- `W`, localparam `$clog2(N)`: index width.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_vec` is valid.
- `in_ready`, output, 1: block can accept a vector this cycle.
- `in_vec`, input, N: request vector.
- `out_valid`, output, 1: an output beat is presented.
- `out_ready`, input, 1: consumer accepts the beat.
- `out_idx`, output, W: index of the current set bit.
- `out_last`, output, 1: final beat for the current vector.
- `out_none`, output, 1: the vector was all-zero; `out_idx` is 0.

## Operation
- **States**
  - IDLE: no vector held.
  - SCAN: a vector is held in the `pending` register.
- **Accept:** a vector is accepted when `in_valid && in_ready`. The accepted vector is loaded into `pending`, and the state moves to SCAN.
- **`in_ready`:** `in_ready = (state==IDLE) || (out_valid && out_ready && out_last)`. This allows back-to-back vectors with no bubble.
- **SCAN outputs**
  - `out_valid` = 1.
  - `out_idx` = position of the lowest set bit of `pending` (LSB_FIRST=1) or the highest set bit (LSB_FIRST=0).
  - `out_last` = 1 when `pending` has exactly one set bit, or is zero.
- **Beat handshake:** on `out_valid && out_ready`, the emitted bit is cleared from `pending`.
  - If `out_last` is set and no new vector is accepted in the same cycle, the state returns to IDLE.
  - If `out_last` is set and a new vector is accepted in the same cycle, the new vector is loaded and the state stays in SCAN.
- **Zero vector:** loads `pending`=0. This gives exactly one beat: `out_none`=1, `out_idx`=0, `out_last`=1.
- **Backpressure:** while `out_valid && !out_ready`, `out_idx`, `out_last` and `out_none` stay stable and `pending` is unchanged.
- **Beat count:** the number of beats per vector equals popcount(`in_vec`), or 1 for a zero vector. Indices are strictly increasing (LSB_FIRST=1) or strictly decreasing (LSB_FIRST=0).
- **Reset values:** state=IDLE, `pending`=0, `out_valid`=0, `out_last`=0, `out_none`=0, `out_idx`=0. `in_ready` is 1 once reset has been asserted.
- **Reset mid-scan:** pending bits are discarded with no further beats. The first accepted vector after reset starts fresh.
- **`in_vec` while busy:** `in_vec` presented while `in_ready`=0 is ignored, and the upstream holds it.

## Timing
- **Latency:** a vector accepted at edge t has its first beat visible on `out_valid`/`out_idx` in the cycle after edge t.
- **Throughput:** one index per cycle under continuous `out_ready`. A K-bit vector occupies K cycles, and the next vector's first beat follows with no idle cycle.
- **Registered vs combinational outputs**
  - `out_idx`, `out_last` and `out_none` are combinational from `pending` only, with no path from `in_vec`.
  - `in_ready` has one combinational path from `out_ready`.
- **Critical path:** the find-first-set over N bits plus the one-bit clear mask. This must meet timing at N=32.

## Structure
- **Shared package `encoder_pkg`:**
  - `state_t` enum {IDLE, SCAN}.
  - Function `clog2_min1(n)`, which returns ≥1 for index widths.
- **Sub-module `priority_encoder`:** combinational and parametrised by N and LSB_FIRST.
  - Outputs `idx`[W-1:0], `onehot`[N-1:0] (the selected bit, used as the clear mask), and `any`.
  - It supersedes the fixed 8-to-3 encoder for new designs.
- **Top level:** FSM, `pending` register, handshake logic.

## Test plan
- **Multi-bit vector:** N=8, LSB_FIRST=1, `in_vec`=8'b1010_0110, `out_ready`=1 → beats `out_idx`=1,2,5,7. `out_last` only on 7, `out_none`=0.
- **Reversed order:** same vector with LSB_FIRST=0 → beats 7,5,2,1. A zero vector → one beat with `out_none`=1, `out_idx`=0, `out_last`=1.
- **Backpressure:** `in_vec`=8'h81, `out_ready` low for 3 cycles → `out_idx`=0 held stable for 3 cycles, then 0 and 7 emitted after release. `in_ready`=0 throughout.
- **Back-to-back:** 8'h03 then 8'h80 offered continuously → beats 0,1,7 on consecutive cycles. The second vector is accepted on the `out_last` beat of the first, with no bubble.
- **Reset mid-scan:** assert `rst_n`=0 after the first beat of 8'hFF → `out_valid`=0 immediately (asynchronous). After release, 8'h10 yields the single beat 4 with `out_last`=1.
- **Random sweep at N=32:** random vectors and random `out_ready` → the scoreboard matches the sequence of set-bit indices and the beat count equals popcount.
